// File: rtl/parity_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx_if
// Description : Bundle of the serial-beat input handshake, the word output
//               handshake and the debug outputs of parity_frame_rx.
// Revision    : 1.0 - initial release
// ============================================================================
interface parity_frame_rx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    // Serial beat channel
    logic              in_valid;
    logic              in_sof;
    logic              in_bit;
    logic              in_ready;

    // Reassembled word channel
    logic [DATA_W-1:0] out_data;
    logic              out_perr;
    logic              out_valid;
    logic              out_ready;

    // Debug
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;

    // Receiver side
    modport slave (
        input  in_valid, in_sof, in_bit, out_ready,
        output in_ready, out_data, out_perr, out_valid, err_cnt, busy
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_sof, in_bit, out_ready,
        input  in_ready, out_data, out_perr, out_valid, err_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx
// Description : Bit-serial frame receiver. Collects DATA_W data bits (LSB
//               first) plus one odd-parity bit, presents the word with a
//               parity-error flag on a valid/ready handshake and keeps a
//               saturating count of bad frames.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    parity_frame_rx_if.slave     bus
);

    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_PAR  = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_acc;
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_perr;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_busy;

    // Even total count of ones (data + parity bit) means a parity error.
    logic w_perr;
    assign w_perr = ~(r_acc ^ bus.in_bit);

    // Frame FSM: bit collection, parity check, output hold and error counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_idx       <= '0;
            r_acc       <= 1'b0;
            r_word      <= '0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_HOLD: begin
                    // Beats are refused here; only the consumer handshake matters.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    if (bus.in_valid) begin
                        if (bus.in_sof) begin
                            // Start of frame, also the resync path from DATA/PAR:
                            // any partial word is thrown away.
                            r_word    <= '0;
                            r_word[0] <= bus.in_bit;
                            r_acc     <= bus.in_bit;
                            r_idx     <= c_IDX_ONE;
                            r_busy    <= 1'b1;
                            if (DATA_W == 1) begin
                                r_state <= c_PAR;
                            end else begin
                                r_state <= c_DATA;
                            end
                        end else if (r_state == c_DATA) begin
                            r_word[r_idx] <= bus.in_bit;
                            r_acc         <= r_acc ^ bus.in_bit;
                            r_idx         <= r_idx + 1'b1;
                            if (r_idx == c_LAST_IDX) begin
                                r_state <= c_PAR;
                            end
                        end else if (r_state == c_PAR) begin
                            r_out_data  <= r_word;
                            r_out_perr  <= w_perr;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_idx       <= '0;
                            r_acc       <= 1'b0;
                            r_state     <= c_HOLD;
                            if (w_perr && (r_err_cnt != c_CNT_MAX)) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                        // IDLE with sof=0: beat dropped silently.
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state != c_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.out_perr  = r_out_perr;
    assign bus.out_valid = r_out_valid;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
